alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
Parametrised, registered ALU with a valid/ready handshake on input and output. It is the successor to the 3-bit-control combinational ALU: WIDTH is configurable, the opcode field is 4 bits, and it adds SRL, SRA, an iterative MUL and illegal-op detection. It sits between the decode/operand-fetch stage and writeback in the pipelined CPU. Single-cycle ops complete in 1 cycle; MUL takes WIDTH cycles.

Parameters:
WIDTH, 32, operand/result width (>= 4, power of 2)
SHAMT_W, $clog2(WIDTH), derived shift-amount width (localparam)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation presented
in_ready  out  1  block can accept; combinational = (state==IDLE) && (!out_valid || out_ready)
op  in  4  0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLT, 7 SLL, 8 SRL, 9 SRA, 10 MUL, 11-15 illegal
a  in  WIDTH  operand A
b  in  WIDTH  operand B (shift amount = b[SHAMT_W-1:0], upper bits ignored)
out_valid  out  1  result/flags registered and valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
zero  out  1  result == 0
negative  out  1  result[WIDTH-1]
overflow  out  1  signed overflow (ADD/SUB only, else 0)
carryout  out  1  ADD: carry out; SUB: borrow (a < b unsigned); MUL: product bits above WIDTH nonzero; else 0
illegal  out  1  op was 11-15
busy  out  1  state == MUL

Behaviour:
- Clock is clk; reset is asynchronous and active-low on rst_n. While rst_n is 0: out_valid=0, result=0, all flags=0, illegal=0, state=IDLE, mul counter=0. in_ready=1 from the first cycle after release.
- Accept on a rising edge with in_valid && in_ready. The output slot drains on out_valid && out_ready. Accept and drain in the same edge is legal, giving back-to-back throughput of 1 op/cycle.
- Single-cycle ops: result and flags are loaded at the accepting edge; out_valid is high from the next cycle. Latency is 1.
- NOP: result=0, zero=1, other flags 0.
- ADD/SUB: (WIDTH+1)-bit arithmetic. overflow = operand signs equal (ADD) or differing (SUB) and result sign differs from a.
- SLT: signed compare; result = {0..., a<b}.
- SLL/SRL: logical shift. SRA: arithmetic shift. A shift amount of 0 returns a unchanged.
- Illegal op: result=0, zero=1, illegal=1, other flags 0, latency 1.
- FSM IDLE -> MUL on accepting op 10. MUL latches a and b, clears the accumulator and loads counter=WIDTH-1.
  - Each cycle in MUL: unsigned shift-add of one multiplier bit. Product width is 2*WIDTH internally.
  - At counter==0 the low WIDTH bits and flags go to the output registers, out_valid=1, and the FSM returns to IDLE.
  - Accepted at edge N, the result is valid after edge N+WIDTH.
  - in_ready=0 and busy=1 throughout MUL. in_valid is ignored.
  - MUL flags: zero and negative computed from the low WIDTH bits, carryout as above, overflow=0.
- Backpressure: while out_valid && !out_ready, result, flags and illegal hold stable and in_ready=0.
- Inputs are not sampled unless accepted. a, b and op may change freely otherwise.
- Reset asserted mid-MUL aborts the operation immediately. No result is produced.

Optional Feature:
ALU_STICKY_FLAGS_EN: when defined, adds input sticky_clr (1 bit) and output sticky_ovf (1 bit).
- sticky_ovf is set on any drained result (out_valid && out_ready) with overflow=1.
- sticky_ovf is cleared by sticky_clr. If set and clear happen in the same cycle, clear wins.
- sticky_ovf resets to 0.
When the macro is undefined, neither port exists and there is no extra state.

Test Plan:
- ADD a=7FFFFFFF b=7FFFFFFF, out_ready=1 -> result FFFFFFFE, overflow=1, carryout=0, negative=1, zero=0, out_valid exactly 1 cycle after accept.
- SUB a=01010101 b=FFFFFFFF -> result 01010102, carryout=1, overflow=0; SUB a=5 b=5 -> result 0, zero=1.
- SLT a=FFFFFFFF b=00000001 -> result 1; SLL a=00000010 b=00000034 (shamt 20) -> 01000000; SRA a=80000000 b=4 -> F8000000.
- MUL a=00000010 b=00000034 -> result 00000340, carryout=0, valid 32 cycles after accept, busy=1 and in_ready=0 throughout; MUL a=FFFFFFFF b=2 -> FFFFFFFE, carryout=1.
- Backpressure: ADD accepted, out_ready=0 for 3 cycles while in_valid=1 with AND -> result held, in_ready=0, AND accepted on the edge out_ready rises, AND result the next cycle; op=4'hC -> illegal=1, result 0.
- Reset pulse (rst_n=0, async, mid-cycle) at MUL cycle 10 -> outputs 0 immediately, busy=0, in_ready=1 after release, no stale out_valid.

Source files
------------

// File: rtl/alu_pipe_if.sv
// Handshake bundle between operand fetch, the pipelined ALU and writeback.
// With ALU_STICKY_FLAGS_EN defined it also carries the sticky overflow clear/status pair.
interface alu_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             negative;
  logic             overflow;
  logic             carryout;
  logic             illegal;
  logic             busy;
`ifdef ALU_STICKY_FLAGS_EN
  logic             sticky_clr;
  logic             sticky_ovf;
`endif

  modport master (
    output in_valid, op, a, b, out_ready,
`ifdef ALU_STICKY_FLAGS_EN
    output sticky_clr,
    input  sticky_ovf,
`endif
    input  in_ready, out_valid, result, zero, negative, overflow, carryout, illegal, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
`ifdef ALU_STICKY_FLAGS_EN
    input  sticky_clr,
    output sticky_ovf,
`endif
    output in_ready, out_valid, result, zero, negative, overflow, carryout, illegal, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake; single-cycle ops plus a WIDTH-cycle shift-add MUL.
// Optional ALU_STICKY_FLAGS_EN adds a sticky overflow flag set by drained overflowing results.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic {IDLE, MUL} state_t;

  state_t               r_state, w_nextState;
  logic [SHAMT_W-1:0]   r_count;
  logic [2*WIDTH-1:0]   r_mcand, r_acc, w_accNext;
  logic [WIDTH-1:0]     r_mplier;
  logic                 r_outValid;
  logic [WIDTH-1:0]     r_result;
  logic                 r_zero, r_negative, r_overflow, r_carry, r_illegal;

  logic                 w_inReady, w_accept, w_drain, w_mulDone, w_isMul;
  logic [SHAMT_W-1:0]   w_shamt;
  logic [WIDTH:0]       w_sum, w_diff;
  logic [WIDTH-1:0]     w_result;
  logic                 w_overflow, w_carry, w_illegal;

  assign w_inReady = (r_state == IDLE) && (!r_outValid || bus.out_ready);
  assign w_accept  = bus.in_valid && w_inReady;
  assign w_drain   = r_outValid && bus.out_ready;
  assign w_isMul   = (bus.op == OP_MUL);
  assign w_mulDone = (r_state == MUL) && (r_count == '0);
  assign w_shamt   = bus.b[SHAMT_W-1:0];
  assign w_sum     = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_diff    = {1'b0, bus.a} - {1'b0, bus.b};
  assign w_accNext = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_accept && w_isMul) w_nextState = MUL;
      MUL:  if (r_count == '0)       w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_result   = '0;
    w_overflow = 1'b0;
    w_carry    = 1'b0;
    w_illegal  = 1'b0;
    case (bus.op)
      OP_NOP: w_result = '0;
      OP_ADD: begin
        w_result   = w_sum[WIDTH-1:0];
        w_carry    = w_sum[WIDTH];
        w_overflow = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        w_result   = w_diff[WIDTH-1:0];
        w_carry    = w_diff[WIDTH];
        w_overflow = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: w_result = bus.a & bus.b;
      OP_OR:  w_result = bus.a | bus.b;
      OP_XOR: w_result = bus.a ^ bus.b;
      OP_SLT: w_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLL: w_result = bus.a << w_shamt;
      OP_SRL: w_result = bus.a >> w_shamt;
      OP_SRA: w_result = $signed(bus.a) >>> w_shamt;
      OP_MUL: w_result = '0;
      default: w_illegal = 1'b1;
    endcase
  end

  // Multiplicand walks left while multiplier bits are consumed LSB-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (w_accept && w_isMul) begin
      r_mcand  <= {{WIDTH{1'b0}}, bus.a};
      r_mplier <= bus.b;
      r_acc    <= '0;
      r_count  <= SHAMT_W'(WIDTH - 1);
    end else if (r_state == MUL) begin
      r_acc    <= w_accNext;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_count != '0) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_overflow <= 1'b0;
      r_carry    <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (w_accept && !w_isMul) begin
      r_outValid <= 1'b1;
      r_result   <= w_result;
      r_zero     <= (w_result == '0);
      r_negative <= w_result[WIDTH-1];
      r_overflow <= w_overflow;
      r_carry    <= w_carry;
      r_illegal  <= w_illegal;
    end else if (w_mulDone) begin
      r_outValid <= 1'b1;
      r_result   <= w_accNext[WIDTH-1:0];
      r_zero     <= (w_accNext[WIDTH-1:0] == '0);
      r_negative <= w_accNext[WIDTH-1];
      r_overflow <= 1'b0;
      r_carry    <= |w_accNext[2*WIDTH-1:WIDTH];
      r_illegal  <= 1'b0;
    end else if (w_drain) begin
      r_outValid <= 1'b0;
    end
  end

`ifdef ALU_STICKY_FLAGS_EN
  logic r_stickyOvf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_stickyOvf <= 1'b0;
    else if (bus.sticky_clr)          r_stickyOvf <= 1'b0;
    else if (w_drain && r_overflow)   r_stickyOvf <= 1'b1;
  end

  assign bus.sticky_ovf = r_stickyOvf;
`endif

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.result    = r_result;
  assign bus.zero      = r_zero;
  assign bus.negative  = r_negative;
  assign bus.overflow  = r_overflow;
  assign bus.carryout  = r_carry;
  assign bus.illegal   = r_illegal;
  assign bus.busy      = (r_state == MUL);
endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe (WIDTH=32): ops, flags, MUL latency, backpressure, reset abort.
module tb_alu_pipe;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compareCount = 0;
  int   mismatchCount = 0;

  alu_pipe_if #(.WIDTH(W)) bus ();
  alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
  endtask

  function automatic logic [4:0] flagVec();
    return {bus.zero, bus.negative, bus.overflow, bus.carryout, bus.illegal};
  endfunction

  // Flags packed as {zero, negative, overflow, carryout, illegal}.
  task automatic doOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] expRes, input logic [4:0] expFlags);
    applyStimulus(op, a, b);
    checkOutput({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checkOutput({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    checkOutput({tag, "_result"}, 64'(bus.result), 64'(expRes));
    checkOutput({tag, "_flags"}, 64'(flagVec()), 64'(expFlags));
    @(posedge clk); #1;
    checkOutput({tag, "_drained"}, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic runMul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expRes, input logic [4:0] expFlags);
    applyStimulus(4'd10, a, b);
    @(posedge clk); #1;
    bus.op = 4'd1;
    checkOutput({tag, "_busy0"}, 64'({bus.busy, bus.in_ready, bus.out_valid}), 64'b100);
    for (int k = 1; k < W; k++) begin
      @(posedge clk); #1;
      checkOutput({tag, "_busy"}, 64'({bus.busy, bus.in_ready, bus.out_valid}), 64'b100);
      if (k == W - 1) bus.in_valid = 1'b0;
    end
    @(posedge clk); #1;
    checkOutput({tag, "_valid"}, 64'({bus.busy, bus.out_valid}), 64'b01);
    checkOutput({tag, "_result"}, 64'(bus.result), 64'(expRes));
    checkOutput({tag, "_flags"}, 64'(flagVec()), 64'(expFlags));
    @(posedge clk); #1;
    checkOutput({tag, "_drained"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic sawValid;
    bus.in_valid = 1'b0;
    bus.op = 4'd0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b1;
`ifdef ALU_STICKY_FLAGS_EN
    bus.sticky_clr = 1'b0;
`endif

    #1;
    checkOutput("rst_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_result", 64'(bus.result), 64'd0);
    checkOutput("rst_flags", 64'(flagVec()), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    doOp("add_ovf",  4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 5'b01100);
`ifdef ALU_STICKY_FLAGS_EN
    checkOutput("sticky_set", 64'(bus.sticky_ovf), 64'd1);
    @(negedge clk); bus.sticky_clr = 1'b1;
    @(negedge clk); bus.sticky_clr = 1'b0;
    checkOutput("sticky_clr", 64'(bus.sticky_ovf), 64'd0);
`endif
    doOp("add_carry", 4'd1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10010);
    doOp("sub_borrow", 4'd2, 32'h01010101, 32'hFFFFFFFF, 32'h01010102, 5'b00010);
    doOp("sub_zero", 4'd2, 32'h00000005, 32'h00000005, 32'h00000000, 5'b10000);
    doOp("xor",      4'd5, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 5'b01000);
    doOp("slt",      4'd6, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'b00000);
    doOp("sll",      4'd7, 32'h00000010, 32'h00000034, 32'h01000000, 5'b00000);
    doOp("sll_zero", 4'd7, 32'h00001234, 32'h00000020, 32'h00001234, 5'b00000);
    doOp("srl",      4'd8, 32'h80000000, 32'h00000004, 32'h08000000, 5'b00000);
    doOp("sra",      4'd9, 32'h80000000, 32'h00000004, 32'hF8000000, 5'b01000);
    doOp("nop",      4'd0, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 5'b10000);
    doOp("illegal",  4'hC, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 5'b10001);

    runMul("mul_small", 32'h00000010, 32'h00000034, 32'h00000340, 5'b00000);
    runMul("mul_wide",  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 5'b01010);

    // Backpressure: ADD held while AND waits, then accept and drain on the same edge.
    bus.out_ready = 1'b0;
    applyStimulus(4'd1, 32'h00000003, 32'h00000004);
    @(posedge clk); #1;
    bus.op = 4'd3;
    bus.a = 32'h0000F0F0;
    bus.b = 32'h0000FF00;
    for (int k = 0; k < 3; k++) begin
      checkOutput("bp_hold_result", 64'(bus.result), 64'h7);
      checkOutput("bp_hold_ready", 64'({bus.out_valid, bus.in_ready}), 64'b10);
      @(posedge clk); #1;
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checkOutput("bp_and_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("bp_and_result", 64'(bus.result), 64'h0000F000);

    // Reset asserted mid-MUL must abort without producing a result.
    applyStimulus(4'd10, 32'h00000003, 32'h00000005);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("abort_result", 64'(bus.result), 64'd0);
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    checkOutput("abort_flags", 64'(flagVec()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("abort_in_ready", 64'(bus.in_ready), 64'd1);
    sawValid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid || bus.busy) sawValid = 1'b1;
    end
    checkOutput("abort_no_stale", 64'(sawValid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end
endmodule
